// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port around dmem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/loader/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Registered arbiter state, exported for observation.
  logic              dbg_locked;
  logic              dbg_last;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output dbg_locked, dbg_last
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  dbg_locked, dbg_last
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the loader,
// with a loader lock and a READ_LAT-deep tag pipeline steering read data back.
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  // Handshake: a requester holds req and its command fields stable until it sees
  // gnt high in the same cycle; that cycle is the transfer. Dropping req first cancels.

  typedef enum logic {
    MODE_OPEN   = 1'b0,
    MODE_LOCKED = 1'b1
  } mode_e;

  mode_e               mode_q, mode_d;
  logic                last_q, last_d;
  logic [READ_LAT-1:0] tag_v_q, tag_v_d;
  logic [READ_LAT-1:0] tag_src_q, tag_src_d;

  logic                cpu_gnt_c, ld_gnt_c;
  logic                mem_en_c, mem_we_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_OPEN;
      last_q    <= 1'b1;
      tag_v_q   <= '0;
      tag_src_q <= '0;
    end else begin
      mode_q    <= mode_d;
      last_q    <= last_d;
      tag_v_q   <= tag_v_d;
      tag_src_q <= tag_src_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_OPEN:   if (ld_gnt_c && bus.ld_lock) mode_d = MODE_LOCKED;
      MODE_LOCKED: if (!bus.ld_lock)            mode_d = MODE_OPEN;
      default:                                  mode_d = MODE_OPEN;
    endcase

    last_d = last_q;
    if (cpu_gnt_c)     last_d = 1'b0;
    else if (ld_gnt_c) last_d = 1'b1;

    // Stage 0 records reads only; the source bit is forced low on non-reads.
    tag_v_d      = tag_v_q;
    tag_src_d    = tag_src_q;
    tag_v_d[0]   = mem_en_c & ~mem_we_c;
    tag_src_d[0] = mem_en_c & ~mem_we_c & ld_gnt_c;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_src_d[i] = tag_src_q[i-1];
    end
  end

  // Output logic: grant and memory command are combinational from requests and state.
  always_comb begin
    cpu_gnt_c = 1'b0;
    ld_gnt_c  = 1'b0;
    if (mode_q == MODE_LOCKED) begin
      ld_gnt_c = bus.ld_req;
    end else if (bus.cpu_req && bus.ld_req) begin
      cpu_gnt_c = last_q;
      ld_gnt_c  = ~last_q;
    end else begin
      cpu_gnt_c = bus.cpu_req;
      ld_gnt_c  = bus.ld_req;
    end

    mem_en_c    = cpu_gnt_c | ld_gnt_c;
    mem_we_c    = (cpu_gnt_c & bus.cpu_we) | (ld_gnt_c & bus.ld_we);
    mem_addr_c  = ld_gnt_c ? bus.ld_addr  : bus.cpu_addr;
    mem_wdata_c = ld_gnt_c ? bus.ld_wdata : bus.cpu_wdata;
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.ld_gnt     = ld_gnt_c;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt_c;
  assign bus.mem_en     = mem_en_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;

  assign bus.cpu_rvalid = tag_v_q[READ_LAT-1] & ~tag_src_q[READ_LAT-1];
  assign bus.ld_rvalid  = tag_v_q[READ_LAT-1] &  tag_src_q[READ_LAT-1];
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ld_rdata   = bus.mem_rdata;

  assign bus.dbg_locked = (mode_q == MODE_LOCKED);
  assign bus.dbg_last   = last_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LAT 1 and 3) driven with identical
// directed stimulus, each with its own memory model and read-response scoreboard.
module tb_dmem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int checks = 0;
  int failures = 0;

  // Shared stimulus
  logic          cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
  logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ld_wdata = '0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.cpu_req = cpu_req;   assign b1.cpu_req = cpu_req;
  assign b0.cpu_we = cpu_we;     assign b1.cpu_we = cpu_we;
  assign b0.cpu_addr = cpu_addr; assign b1.cpu_addr = cpu_addr;
  assign b0.cpu_wdata = cpu_wdata; assign b1.cpu_wdata = cpu_wdata;
  assign b0.ld_req = ld_req;     assign b1.ld_req = ld_req;
  assign b0.ld_we = ld_we;       assign b1.ld_we = ld_we;
  assign b0.ld_addr = ld_addr;   assign b1.ld_addr = ld_addr;
  assign b0.ld_wdata = ld_wdata; assign b1.ld_wdata = ld_wdata;
  assign b0.ld_lock = ld_lock;   assign b1.ld_lock = ld_lock;

  // Observation vectors, index 0 = READ_LAT 1, index 1 = READ_LAT 3
  logic [1:0]    o_cg, o_lg, o_st, o_en, o_we, o_cv, o_lv, o_lk, o_last;
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wd [2];
  logic [DW-1:0] o_crd [2];
  logic [DW-1:0] o_lrd [2];
  assign o_cg   = {b1.cpu_gnt, b0.cpu_gnt};
  assign o_lg   = {b1.ld_gnt, b0.ld_gnt};
  assign o_st   = {b1.cpu_stall, b0.cpu_stall};
  assign o_en   = {b1.mem_en, b0.mem_en};
  assign o_we   = {b1.mem_we, b0.mem_we};
  assign o_cv   = {b1.cpu_rvalid, b0.cpu_rvalid};
  assign o_lv   = {b1.ld_rvalid, b0.ld_rvalid};
  assign o_lk   = {b1.dbg_locked, b0.dbg_locked};
  assign o_last = {b1.dbg_last, b0.dbg_last};
  assign o_addr[0] = b0.mem_addr;  assign o_addr[1] = b1.mem_addr;
  assign o_wd[0]   = b0.mem_wdata; assign o_wd[1]   = b1.mem_wdata;
  assign o_crd[0]  = b0.cpu_rdata; assign o_crd[1]  = b1.cpu_rdata;
  assign o_lrd[0]  = b0.ld_rdata;  assign o_lrd[1]  = b1.ld_rdata;

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1 [3];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i]   = init_val(i);
      mem1[i]   = init_val(i);
      shadow[i] = init_val(i);
    end
  end

  always @(posedge clk) begin
    rd0 <= (b0.mem_en && !b0.mem_we) ? mem0[b0.mem_addr] : 32'hBAD0_BAD0;
    if (b0.mem_en && b0.mem_we) mem0[b0.mem_addr] = b0.mem_wdata;
  end
  assign b0.mem_rdata = rd0;

  always @(posedge clk) begin
    rd1[0] <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 32'hBAD1_BAD1;
    rd1[1] <= rd1[0];
    rd1[2] <= rd1[1];
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] = b1.mem_wdata;
  end
  assign b1.mem_rdata = rd1[2];

  // ---------------- scoreboard ----------------
  // entry = {src, data, due_cycle}
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic src, input logic [AW-1:0] a);
    exp_q0.push_back({src, shadow[a], 32'(cycle_cnt + 1)});
    exp_q1.push_back({src, shadow[a], 32'(cycle_cnt + 3)});
  endtask

  task automatic mon(input int d);
    logic [64:0] f;
    logic have, ev;
    f = '0;
    have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    if (have) begin
      if (d == 0) f = exp_q0[0];
      else        f = exp_q1[0];
    end
    ev = have && (f[31:0] == 32'(cycle_cnt));
    chk($sformatf("rvalid/d%0d/cyc%0d", d, cycle_cnt), {62'b0, o_cv[d], o_lv[d]},
        {62'b0, ev & ~f[64], ev & f[64]});
    if (ev) begin
      chk($sformatf("rdata/d%0d/cyc%0d", d, cycle_cnt),
          f[64] ? o_lrd[d] : o_crd[d], f[63:32]);
      if (d == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input string tag,
                      input logic cr, input logic cwe, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd,
                      input logic lr, input logic lwe, input logic [AW-1:0] la,
                      input logic [DW-1:0] ldt, input logic lk,
                      input logic exp_cg, input logic exp_lg);
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    ld_req = lr;  ld_we = lwe;  ld_addr = la;  ld_wdata = ldt; ld_lock = lk;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/cpu_gnt/d%0d", tag, d), o_cg[d], exp_cg);
      chk($sformatf("%s/ld_gnt/d%0d", tag, d), o_lg[d], exp_lg);
      chk($sformatf("%s/cpu_stall/d%0d", tag, d), o_st[d], cr & ~exp_cg);
      chk($sformatf("%s/mem_en/d%0d", tag, d), o_en[d], exp_cg | exp_lg);
      chk($sformatf("%s/mem_we/d%0d", tag, d), o_we[d], (exp_cg & cwe) | (exp_lg & lwe));
      if (exp_cg | exp_lg)
        chk($sformatf("%s/mem_addr/d%0d", tag, d), o_addr[d], exp_lg ? la : ca);
      if ((exp_cg & cwe) | (exp_lg & lwe))
        chk($sformatf("%s/mem_wdata/d%0d", tag, d), o_wd[d], exp_lg ? ldt : cd);
    end
    if (exp_cg && !cwe) push_rd(1'b0, ca);
    if (exp_cg && cwe)  shadow[ca] = cd;
    if (exp_lg && !lwe) push_rd(1'b1, la);
    if (exp_lg && lwe)  shadow[la] = ldt;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step("idle", 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic chk_state(input string tag, input logic locked, input logic last);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/locked/d%0d", tag, d), o_lk[d], locked);
      chk($sformatf("%s/last/d%0d", tag, d), o_last[d], last);
    end
  endtask

  task automatic do_reset(input string tag);
    cpu_req = 0; cpu_we = 0; ld_req = 0; ld_we = 0; ld_lock = 0;
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/rst_gnt/d%0d", tag, d), {o_cg[d], o_lg[d]}, 2'b00);
      chk($sformatf("%s/rst_rvalid/d%0d", tag, d), {o_cv[d], o_lv[d]}, 2'b00);
      chk($sformatf("%s/rst_mem/d%0d", tag, d), {o_en[d], o_we[d]}, 2'b00);
    end
    chk_state({tag, "/rst"}, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] ca, la;
    @(posedge clk); #1;
    do_reset("init");

    // Single CPU read
    step("cpu_rd10", 1, 0, 14'h010, '0, 0, 0, '0, '0, 0, 1, 0);
    idle(4);

    // Both requesting continuously: CPU, LD, CPU, LD, CPU, LD
    do_reset("fair");
    ca = 14'h040;
    la = 14'h080;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("fair%0d", i), 1, 0, ca, '0, 1, 0, la, '0, 0,
           (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) ca = ca + 1;
      else              la = la + 1;
    end
    idle(4);

    // Loader lock burst
    step("ld_wr_lock", 0, 0, '0, '0, 1, 1, 14'h020, 32'hDEAD_BEEF, 1, 0, 1);
    chk_state("locked", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step($sformatf("locked_cpu%0d", i), 1, 0, 14'h020, '0, 0, 0, '0, '0, 1, 0, 0);
    step("lock_fall", 1, 0, 14'h020, '0, 1, 0, 14'h021, '0, 0, 0, 1);
    chk_state("unlocked", 1'b0, 1'b1);
    step("cpu_after_lock", 1, 0, 14'h020, '0, 0, 0, '0, '0, 0, 1, 0);
    idle(4);

    // Alternating reads returning back to back
    step("alt_cpu1", 1, 0, 14'h001, '0, 0, 0, '0, '0, 0, 1, 0);
    step("alt_ld2", 0, 0, '0, '0, 1, 0, 14'h002, '0, 0, 0, 1);
    step("alt_cpu3", 1, 0, 14'h003, '0, 0, 0, '0, '0, 0, 1, 0);
    idle(4);

    // Reset with reads in flight and a lock held
    do_reset("pre_mid");
    step("mid_cpu5", 1, 0, 14'h005, '0, 0, 0, '0, '0, 0, 1, 0);
    step("mid_ld6", 0, 0, '0, '0, 1, 0, 14'h006, '0, 1, 0, 1);
    do_reset("mid");
    step("tie_after_rst", 1, 0, 14'h007, '0, 1, 0, 14'h008, '0, 0, 1, 0);
    step("ld_after_tie", 0, 0, '0, '0, 1, 0, 14'h008, '0, 0, 0, 1);
    idle(5);

    // Store then load same address
    step("cpu_st4", 1, 1, 14'h004, 32'h1234_5678, 0, 0, '0, '0, 0, 1, 0);
    step("cpu_ld4", 1, 0, 14'h004, '0, 0, 0, '0, '0, 0, 1, 0);
    idle(4);

    // Random single-requester traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic we;
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      sel = $urandom_range(0, 2);
      we  = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 31));
      v   = $urandom;
      if (sel == 1)      step($sformatf("rnd_cpu%0d", i), 1, we, a, v, 0, 0, '0, '0, 0, 1, 0);
      else if (sel == 2) step($sformatf("rnd_ld%0d", i), 0, 0, '0, '0, 1, we, a, v, 0, 0, 1);
      else               idle(1);
    end
    idle(5);

    chk("queue_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU load/store path and a second requester, the program/data loader (UART or debug). It sits between the CPU's memory-access signals and the data memory. Requests are granted in the same cycle under round-robin arbitration, with an optional loader lock for bursts. A latency-matched tag pipeline routes read data back to the correct requester.

## Interface
Parameters:
- ADDR_W, 14, word-address width
- DATA_W, 32, data width
- READ_LAT, 1, memory read latency in cycles (legal 1..4)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request (level, held until granted)
- cpu_we  in  1  CPU write enable (1 = store, 0 = load)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the CPU pc/pipeline
- cpu_rvalid  out  1  CPU load data valid on cpu_rdata
- cpu_rdata  out  DATA_W  CPU load data
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request; same meaning as the CPU signals
- ld_lock  in  1  loader requests exclusive ownership after its next grant
- ld_gnt, ld_rvalid  out  1  loader grant and read-valid
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after a read strobe

## Operation
- At most one access per cycle.
  - Grant is combinational from the requests and the registered state.
  - The memory command equals the winner's request in the same cycle; memory samples it at the next posedge.
- Registered state:
  - last: last granted requester, 0 = CPU, 1 = loader
  - mode: OPEN or LOCKED
  - tag pipeline: READ_LAT stages of {valid, src}
- OPEN arbitration:
  - One requester active: it wins.
  - Both active: the requester that is not `last` wins.
  - Neither active: mem_en = 0; mem_addr, mem_wdata and mem_we are don't-care but mem_we must be 0.
- LOCKED arbitration: only the loader can win; cpu_gnt = 0.
- mode transitions, evaluated at posedge:
  - OPEN → LOCKED when ld_gnt & ld_lock.
  - LOCKED → OPEN when ld_lock = 0.
  - While LOCKED, ld_req may drop without releasing the lock.
- `last` updates to the winner on every granted cycle and holds otherwise.
- Read return:
  - A granted read pushes {1, src} into tag stage 0; a write or idle cycle pushes {0, x}.
  - At the final stage: cpu_rvalid = valid & (src == 0), ld_rvalid = valid & (src == 1).
  - cpu_rdata and ld_rdata are both driven from mem_rdata. Only the matching rvalid qualifies the data.
- Writes produce no response. The write completes at the posedge that ends the grant cycle.

## Timing
- Reset (asynchronous):
  - last = 1, so the CPU wins the first tie.
  - mode = OPEN.
  - All tag valids = 0.
  - All outputs derived from the reset state are 0: gnt, rvalid, mem_en, mem_we.
- Grant-to-rvalid latency is exactly READ_LAT cycles; the response is fully pipelined, so back-to-back reads return back-to-back.
- Fairness in OPEN: with both requesting continuously, grants alternate, so CPU stall is at most 1 cycle per access. LOCKED starvation is unbounded by design and is the loader's responsibility.
- Reset mid-operation: in-flight tags are cleared, so no rvalid is issued for reads granted before reset. A lock held at reset is dropped.
- Simultaneous lock release and request: in the cycle ld_lock falls, mode is still LOCKED, so the loader still wins. Normal arbitration applies the next cycle.
- Requester rule: req and command fields must be held stable until gnt. Dropping req before gnt is legal and cancels the request.

## Test plan
- Reset, then cpu_req=1 read at addr 0x010 with ld_req=0 → cpu_gnt=1 in the same cycle, mem_en=1, mem_we=0, mem_addr=0x010. cpu_rvalid=1 exactly READ_LAT cycles later with the memory value. ld_rvalid stays 0.
- Both requesting continuously for 6 cycles after reset → grant order CPU, LD, CPU, LD, CPU, LD. cpu_stall=1 on the LD cycles.
- Loader write 0xDEADBEEF to 0x020 with ld_lock=1, then CPU requests for 4 cycles while ld_lock stays high → cpu_gnt=0 throughout. Drop ld_lock → CPU granted within 2 cycles. A CPU read of 0x020 returns 0xDEADBEEF.
- READ_LAT=3, alternating reads CPU@0x001, LD@0x002, CPU@0x003 on consecutive cycles → rvalid pattern cpu, ld, cpu on 3 consecutive cycles, each carrying its own address's data.
- Assert rst one cycle after two granted reads → no rvalid pulses afterwards. mode = OPEN, and the first tie after reset goes to the CPU.
- CPU store 0x12345678 to 0x004 followed immediately by a CPU load of 0x004 → load returns 0x12345678. mem_we=1 only in the store cycle.
